alu_issue_ctrl: RTL and testbench

Issue-side controller for the 32-bit MIPS ALU: accepts one decoded-register instruction at a time over a valid/ready handshake, decodes it into the ALU's 5-bit ALUC code and A/B operands, samples the ALU's combinational result and flags, and returns a write-back packet over a second valid/ready handshake. It is the initiator of the ALU operand/opcode interface. It converts raw ALU outputs into architectural results: SLT/SLTU 0/1 values, true signed overflow, and register-0 write suppression.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_issue_decode.sv | 80 ++++++++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the MIPS ALU issue controller: ALUC codes, opcode/funct
// encodings, trap codes and the issue FSM state type.
package alu_pkg;

    localparam logic [4:0] ALUC_ADD  = 5'b00000;
    localparam logic [4:0] ALUC_ADDU = 5'b00001;
    localparam logic [4:0] ALUC_SUB  = 5'b00010;
    localparam logic [4:0] ALUC_SUBU = 5'b00011;
    localparam logic [4:0] ALUC_AND  = 5'b00100;
    localparam logic [4:0] ALUC_OR   = 5'b00101;
    localparam logic [4:0] ALUC_XOR  = 5'b00110;
    localparam logic [4:0] ALUC_NOR  = 5'b00111;
    localparam logic [4:0] ALUC_SLT  = 5'b01000;
    localparam logic [4:0] ALUC_SLTU = 5'b01001;
    localparam logic [4:0] ALUC_SLL  = 5'b01010;
    localparam logic [4:0] ALUC_SRL  = 5'b01011;
    localparam logic [4:0] ALUC_SRA  = 5'b01100;
    localparam logic [4:0] ALUC_SLLV = 5'b01101;
    localparam logic [4:0] ALUC_SRLV = 5'b01110;
    localparam logic [4:0] ALUC_SRAV = 5'b01111;
    localparam logic [4:0] ALUC_LUI  = 5'b10000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] TRAP_NONE = 2'b00;
    localparam logic [1:0] TRAP_ILL  = 2'b01;
    localparam logic [1:0] TRAP_OVF  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of a MIPS instruction plus register operands into the
// ALU opcode, A/B operands, destination register and result-handling flags.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    output logic [4:0]    aluc,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [4:0]    rd,
    output logic          is_slt,
    output logic          chk_ovf,
    output logic          legal
);

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [DW-1:0] shamt_z;
    logic [DW-1:0] imm_s;
    logic [DW-1:0] imm_z;
    logic          unused_rs_field;

    assign opcode  = instr[31:26];
    assign funct   = instr[5:0];
    assign shamt_z = {{(DW-5){1'b0}}, instr[10:6]};
    assign imm_s   = {{(DW-16){instr[15]}}, instr[15:0]};
    assign imm_z   = {{(DW-16){1'b0}}, instr[15:0]};
    // The rs field only selects a register upstream; its value arrives on rs_val.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        aluc    = ALUC_ADD;
        alu_a   = rs_val;
        alu_b   = rt_val;
        rd      = instr[15:11];
        is_slt  = 1'b0;
        chk_ovf = 1'b0;
        legal   = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  begin aluc = ALUC_ADD; chk_ovf = 1'b1; end
                FN_ADDU: aluc = ALUC_ADDU;
                FN_SUB:  begin aluc = ALUC_SUB; chk_ovf = 1'b1; end
                FN_SUBU: aluc = ALUC_SUBU;
                FN_AND:  aluc = ALUC_AND;
                FN_OR:   aluc = ALUC_OR;
                FN_XOR:  aluc = ALUC_XOR;
                FN_NOR:  aluc = ALUC_NOR;
                FN_SLT:  begin aluc = ALUC_SLT;  is_slt = 1'b1; end
                FN_SLTU: begin aluc = ALUC_SLTU; is_slt = 1'b1; end
                FN_SLL:  begin aluc = ALUC_SLL; alu_a = shamt_z; end
                FN_SRL:  begin aluc = ALUC_SRL; alu_a = shamt_z; end
                FN_SRA:  begin aluc = ALUC_SRA; alu_a = shamt_z; end
                FN_SLLV: aluc = ALUC_SLLV;
                FN_SRLV: aluc = ALUC_SRLV;
                FN_SRAV: aluc = ALUC_SRAV;
                default: legal = 1'b0;
            endcase
        end else begin
            rd    = instr[20:16];
            alu_b = imm_s;
            case (opcode)
                OP_ADDI:  begin aluc = ALUC_ADD; chk_ovf = 1'b1; end
                OP_ADDIU: aluc = ALUC_ADDU;
                OP_SLTI:  begin aluc = ALUC_SLT;  is_slt = 1'b1; end
                OP_SLTIU: begin aluc = ALUC_SLTU; is_slt = 1'b1; end
                OP_ANDI:  begin aluc = ALUC_AND; alu_b = imm_z; end
                OP_ORI:   begin aluc = ALUC_OR;  alu_b = imm_z; end
                OP_XORI:  begin aluc = ALUC_XOR; alu_b = imm_z; end
                OP_LUI:   begin aluc = ALUC_LUI; alu_b = imm_z; end
                default:  legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational MIPS ALU: IDLE -> EXEC -> RESP handshake
// FSM. Build option ALU_ISSUE_OVF_TRAP_EN turns signed ADD/SUB overflow into a trap.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [4:0]    aluc,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_sign,
    input  logic          alu_zero,
    input  logic          alu_carry,
    input  logic          alu_overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_rd,
    output logic          out_wr_en,
    output logic [1:0]    out_trap
);

    function automatic logic add_sub_ovf(input logic signed [DW-1:0] a,
                                         input logic signed [DW-1:0] b,
                                         input logic signed [DW-1:0] res,
                                         input logic                 is_sub);
        logic signed [DW-1:0] b_eff;
        b_eff = is_sub ? ~b : b;
        return (a[DW-1] == b_eff[DW-1]) && (res[DW-1] != a[DW-1]);
    endfunction

    state_e        state, state_nx;
    logic [4:0]    dec_aluc;
    logic [DW-1:0] dec_a, dec_b;
    logic [4:0]    dec_rd;
    logic          dec_is_slt, dec_chk_ovf, dec_legal;
    logic [4:0]    rd_p1;
    logic          is_slt_p1, chk_ovf_p1;
    logic          accept;
    logic          ovf_hit, ovf_trap;
    logic          unused_alu_flags;

    // The ALU's own overflow flag is not architectural signed overflow.
    assign unused_alu_flags = alu_zero ^ alu_carry ^ alu_overflow;

    alu_issue_decode #(.DW(DW)) u_decode (
        .instr   (instr),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .aluc    (dec_aluc),
        .alu_a   (dec_a),
        .alu_b   (dec_b),
        .rd      (dec_rd),
        .is_slt  (dec_is_slt),
        .chk_ovf (dec_chk_ovf),
        .legal   (dec_legal)
    );

    assign accept  = in_ready && in_valid;
    assign ovf_hit = chk_ovf_p1 &&
                     add_sub_ovf($signed(alu_a), $signed(alu_b), $signed(alu_res),
                                 aluc == ALUC_SUB);

`ifdef ALU_ISSUE_OVF_TRAP_EN
    assign ovf_trap = ovf_hit;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_hit;
    assign ovf_trap   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = dec_legal ? S_EXEC : S_RESP;
            end
            S_EXEC: state_nx = S_RESP;
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // p0 -> p1: capture decode at accept; illegal ops skip the ALU and respond directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            aluc       <= '0;
            rd_p1      <= '0;
            is_slt_p1  <= 1'b0;
            chk_ovf_p1 <= 1'b0;
            out_data   <= '0;
            out_rd     <= '0;
            out_wr_en  <= 1'b0;
            out_trap   <= TRAP_NONE;
        end else begin
            if (accept) begin
                rd_p1      <= dec_rd;
                is_slt_p1  <= dec_is_slt;
                chk_ovf_p1 <= dec_chk_ovf;
                if (dec_legal) begin
                    alu_a <= dec_a;
                    alu_b <= dec_b;
                    aluc  <= dec_aluc;
                end else begin
                    out_data  <= '0;
                    out_rd    <= '0;
                    out_wr_en <= 1'b0;
                    out_trap  <= TRAP_ILL;
                end
            end
            // p1 -> p2: sample the ALU at the end of EXEC into the response packet
            if (state == S_EXEC) begin
                out_data  <= is_slt_p1 ? {{(DW-1){1'b0}}, alu_sign} : alu_res;
                out_rd    <= rd_p1;
                out_wr_en <= (rd_p1 != 5'd0) && !ovf_trap;
                out_trap  <= ovf_trap ? TRAP_OVF : TRAP_NONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU stub, instruction-level
// reference model, directed and randomized transactions.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  aluc;
    logic [31:0] alu_res;
    logic        alu_sign;
    logic        alu_zero = 1'b0;
    logic        alu_carry = 1'b0;
    logic        alu_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wr_en;
    logic [1:0]  out_trap;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_d;
    logic [4:0]  exp_rd;
    logic        exp_wr;
    logic [1:0]  exp_trap;
    logic        exp_ill;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc),
        .alu_res(alu_res), .alu_sign(alu_sign),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_wr_en(out_wr_en), .out_trap(out_trap)
    );

    // Combinational ALU stub driven by the DUT's operand/opcode interface.
    always_comb begin
        alu_res  = '0;
        alu_sign = alu_a[0] ^ alu_b[0];
        case (aluc)
            5'b00000, 5'b00001: alu_res = alu_a + alu_b;
            5'b00010, 5'b00011: alu_res = alu_a - alu_b;
            5'b00100: alu_res = alu_a & alu_b;
            5'b00101: alu_res = alu_a | alu_b;
            5'b00110: alu_res = alu_a ^ alu_b;
            5'b00111: alu_res = ~(alu_a | alu_b);
            5'b01000: begin alu_res = alu_a - alu_b; alu_sign = $signed(alu_a) < $signed(alu_b); end
            5'b01001: begin alu_res = alu_a - alu_b; alu_sign = alu_a < alu_b; end
            5'b01010, 5'b01101: alu_res = alu_b << alu_a[4:0];
            5'b01011, 5'b01110: alu_res = alu_b >> alu_a[4:0];
            5'b01100, 5'b01111: alu_res = $signed(alu_b) >>> alu_a[4:0];
            5'b10000: alu_res = {alu_b[15:0], 16'h0000};
            default:  alu_res = 32'hDEAD_BEEF;
        endcase
    end

    // Instruction-level reference: architectural result straight from MIPS semantics.
    task automatic model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [31:0] simm, zimm;
        logic [32:0] s33;
        logic        ovf;
        op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0000, ins[15:0]};
        exp_ill = 1'b0; ovf = 1'b0; exp_d = '0; s33 = '0;
        if (op == 6'h00) begin
            exp_rd = ins[15:11];
            case (fn)
                6'h20: begin s33 = {rs[31], rs} + {rt[31], rt}; exp_d = s33[31:0]; ovf = s33[32] != s33[31]; end
                6'h21: exp_d = rs + rt;
                6'h22: begin s33 = {rs[31], rs} - {rt[31], rt}; exp_d = s33[31:0]; ovf = s33[32] != s33[31]; end
                6'h23: exp_d = rs - rt;
                6'h24: exp_d = rs & rt;
                6'h25: exp_d = rs | rt;
                6'h26: exp_d = rs ^ rt;
                6'h27: exp_d = ~(rs | rt);
                6'h2A: exp_d = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2B: exp_d = (rs < rt) ? 32'd1 : 32'd0;
                6'h00: exp_d = rt << sh;
                6'h02: exp_d = rt >> sh;
                6'h03: exp_d = $signed(rt) >>> sh;
                6'h04: exp_d = rt << rs[4:0];
                6'h06: exp_d = rt >> rs[4:0];
                6'h07: exp_d = $signed(rt) >>> rs[4:0];
                default: exp_ill = 1'b1;
            endcase
        end else begin
            exp_rd = ins[20:16];
            case (op)
                6'h08: begin s33 = {rs[31], rs} + {simm[31], simm}; exp_d = s33[31:0]; ovf = s33[32] != s33[31]; end
                6'h09: exp_d = rs + simm;
                6'h0A: exp_d = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0;
                6'h0B: exp_d = (rs < simm) ? 32'd1 : 32'd0;
                6'h0C: exp_d = rs & zimm;
                6'h0D: exp_d = rs | zimm;
                6'h0E: exp_d = rs ^ zimm;
                6'h0F: exp_d = {ins[15:0], 16'h0000};
                default: exp_ill = 1'b1;
            endcase
        end
        if (exp_ill) begin
            exp_trap = 2'b01; exp_wr = 1'b0;
        end else begin
`ifdef ALU_ISSUE_OVF_TRAP_EN
            exp_trap = ovf ? 2'b10 : 2'b00;
            exp_wr   = !ovf && (exp_rd != 5'd0);
`else
            exp_trap = 2'b00;
            exp_wr   = (exp_rd != 5'd0);
`endif
        end
    endtask

    // Present one instruction, wait for the response; returns in RESP at #1 after an edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input string tag);
        int w;
        int lat;
        logic ok;
        model(ins, rs, rt);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready timeout got=%b want=1", tag, in_ready); end
        instr = ins; rs_val = rs; rt_val = rt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; instr = $urandom; rs_val = $urandom; rt_val = $urandom;
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (lat != (exp_ill ? 1 : 2)) begin n_fail++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_ill ? 1 : 2); end
        if (exp_ill) ok = (out_trap === 2'b01) && (out_wr_en === 1'b0);
        else ok = ({out_data, out_rd, out_wr_en, out_trap} === {exp_d, exp_rd, exp_wr, exp_trap});
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s packet got data=%h rd=%0d wr=%b trap=%b want data=%h rd=%0d wr=%b trap=%b (instr=%h)",
                     tag, out_data, out_rd, out_wr_en, out_trap, exp_d, exp_rd, exp_wr, exp_trap, ins);
        end
    endtask

    // Hold out_ready low for dly cycles checking the held packet, then complete the handshake.
    task automatic finish_txn(input int dly, input string tag);
        logic ok;
        out_ready = 1'b0;
        for (int c = 0; c < dly; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s hold%0d valid/ready got=%b%b want=10", tag, c, out_valid, in_ready);
            end
            if (exp_ill) ok = (out_trap === 2'b01) && (out_wr_en === 1'b0);
            else ok = ({out_data, out_rd, out_wr_en, out_trap} === {exp_d, exp_rd, exp_wr, exp_trap});
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL %s hold%0d packet got data=%h wr=%b trap=%b want data=%h wr=%b trap=%b",
                                   tag, c, out_data, out_wr_en, out_trap, exp_d, exp_wr, exp_trap);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s release valid/ready got=%b%b want=01", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_wr_en, out_trap, out_data, out_rd, alu_a, alu_b, aluc} !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_state got valid=%b wr=%b trap=%b data=%h rd=%0d a=%h b=%h aluc=%b rdy=%b want all zero, rdy=1",
                               out_valid, out_wr_en, out_trap, out_data, out_rd, alu_a, alu_b, aluc, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h5, 32'h7, "addu");
        n_tests++;
        if ({aluc, out_data, out_rd, out_wr_en} !== {5'b00001, 32'h0000_000C, 5'd3, 1'b1}) begin
            n_fail++; $display("FAIL addu_const got aluc=%b data=%h rd=%0d wr=%b want 00001 0000000c 3 1", aluc, out_data, out_rd, out_wr_en);
        end
        finish_txn(5, "addu_stall");

        issue({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 32'h7FFF_FFFF, 32'h1, "add_ovf");
        n_tests++;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        if (out_trap !== 2'b10 || out_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL add_ovf_const got trap=%b wr=%b want 10 0", out_trap, out_wr_en);
        end
`else
        if (out_data !== 32'h8000_0000 || out_wr_en !== 1'b1 || out_trap !== 2'b00) begin
            n_fail++; $display("FAIL add_ovf_const got data=%h wr=%b trap=%b want 80000000 1 00", out_data, out_wr_en, out_trap);
        end
`endif
        finish_txn(0, "add_ovf");

        issue({6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h2A}, 32'hFFFF_FFFF, 32'h1, "slt");
        n_tests++;
        if (out_data !== 32'd1) begin n_fail++; $display("FAIL slt_const got=%h want=00000001", out_data); end
        finish_txn(1, "slt");

        issue({6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h2B}, 32'hFFFF_FFFF, 32'h1, "sltu");
        n_tests++;
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL sltu_const got=%h want=00000000", out_data); end
        finish_txn(0, "sltu");

        issue({6'h00, 5'd0, 5'd2, 5'd6, 5'd4, 6'h03}, 32'h1234_5678, 32'h8000_0000, "sra");
        n_tests++;
        if (alu_a !== 32'd4 || out_data !== 32'hF800_0000) begin
            n_fail++; $display("FAIL sra_const got a=%h data=%h want 00000004 f8000000", alu_a, out_data);
        end
        finish_txn(0, "sra");

        issue({6'h0F, 5'd0, 5'd0, 16'h1234}, 32'h0, 32'h0, "lui_r0");
        n_tests++;
        if (out_data !== 32'h1234_0000 || out_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL lui_const got data=%h wr=%b want 12340000 0", out_data, out_wr_en);
        end
        finish_txn(0, "lui_r0");

        issue({6'h3F, 26'h0}, 32'h1, 32'h2, "illegal");
        n_tests++;
        if (out_trap !== 2'b01 || out_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL illegal_const got trap=%b wr=%b want 01 0", out_trap, out_wr_en);
        end
        finish_txn(2, "illegal");
    endtask

    task automatic test_back_to_back();
        int acc;
        int hs;
        acc = 0; hs = 0;
        @(negedge clk);
        instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}; rs_val = $urandom; rt_val = $urandom;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) hs++;
        end
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b0;
        n_tests++;
        if (acc != 10 || hs != 10) begin
            n_fail++; $display("FAIL b2b_rate got accepts=%0d responses=%0d want 10 10", acc, hs);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}; rs_val = 32'h10; rt_val = 32'h20; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || aluc !== 5'b0 || alu_a !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_async got valid=%b aluc=%b a=%h want 0 0 0", out_valid, aluc, alu_a);
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_release got valid=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_packet got=%0d want=0 valid cycles", seen); end
    endtask

    task automatic test_random();
        logic [5:0]  rfn [16];
        logic [5:0]  iop [8];
        logic [31:0] vals [5];
        logic [31:0] ins, a, b;
        int k;
        rfn  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        iop  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        vals = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 150; i++) begin
            ins = $urandom;
            k = $urandom_range(0, 9);
            if (k < 5) begin
                ins[31:26] = 6'h00; ins[5:0] = rfn[$urandom_range(0, 15)];
            end else if (k < 9) begin
                ins[31:26] = iop[$urandom_range(0, 7)];
            end
            a = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? vals[$urandom_range(0, 4)] : $urandom;
            issue(ins, a, b, "rand");
            finish_txn($urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
